lfsr_encryptor: RTL and testbench

- Transmit-side counterpart of the team's LFSR stream decryptor.
- Holds a 256x8 data memory that the host loads with plaintext.
- On a start pulse, writes a fixed-byte preamble followed by the message into the memory's output region. Every output byte is XORed with a 6-bit LFSR keystream.
- The ciphertext image it produces is the exact input format the decryptor consumes.

---
 rtl/lfsr_encryptor.sv | 195 +++++++++++++++++++
 tb/tb_lfsr_encryptor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_encryptor.sv
// lfsr_encryptor: 256x8 memory plus an engine that writes a preamble and the
// stored plaintext, each byte XORed with a 6-bit Fibonacci LFSR keystream,
// into the ciphertext region starting at OUT_BASE.
module lfsr_encryptor #(
  parameter logic [7:0] PRE_CHAR = 8'h5F,
  parameter int         OUT_BASE = 64
) (
  input  logic       clk,
  input  logic       init,
  input  logic       start,
  input  logic       wr_en,
  input  logic [7:0] waddr,
  input  logic [7:0] data_in,
  input  logic [7:0] raddr,
  output logic [7:0] data_out,
  input  logic [5:0] lfsr_seed,
  input  logic [2:0] tap_sel,
  input  logic [5:0] pre_len,
  input  logic [5:0] msg_len,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LP_OUT_BASE = 8'(OUT_BASE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // Tap pattern table; unused indices fall back to the first pattern.
  function automatic logic [5:0] tap_lookup(input logic [2:0] sel);
    logic [5:0] taps;
    case (sel)
      3'd0:    taps = 6'h21;
      3'd1:    taps = 6'h2D;
      3'd2:    taps = 6'h30;
      3'd3:    taps = 6'h33;
      3'd4:    taps = 6'h36;
      3'd5:    taps = 6'h39;
      default: taps = 6'h21;
    endcase
    return taps;
  endfunction

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] taps);
    return {s[4:0], ^(s & taps)};
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_k;          // index of the next output byte
  logic [5:0] r_lfsr;
  logic [5:0] r_taps;
  logic [5:0] r_pre_len;
  logic [5:0] r_msg_len;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_data_out;
  logic [7:0] r_rd_data;    // engine read of the current plaintext byte
  logic [7:0] r_mem [0:255];

  logic       w_start_acc;
  logic       w_pre_last;
  logic       w_msg_last;
  logic       w_eng_we;
  logic [7:0] w_eng_addr;
  logic [7:0] w_eng_wdata;
  logic [7:0] w_src_addr;
  logic [7:0] w_src_byte;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_pre_last  = ((r_k + 7'd1) == {1'b0, r_pre_len});
  assign w_msg_last  = ((r_k + 7'd1) == ({1'b0, r_pre_len} + {1'b0, r_msg_len}));
  assign w_eng_we    = (r_state == S_PRE) || (r_state == S_WR);
  assign w_eng_addr  = LP_OUT_BASE + {1'b0, r_k};
  // Plaintext index is the output index minus the preamble length; only used in RD.
  assign w_src_addr  = {1'b0, r_k - {1'b0, r_pre_len}};
  assign w_src_byte  = (r_state == S_PRE) ? PRE_CHAR : r_rd_data;
  assign w_eng_wdata = w_src_byte ^ {2'b00, r_lfsr};

  assign data_out = r_data_out;
  assign busy     = r_busy;
  assign done     = r_done;

  // State register.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the preamble and message phases are skipped when empty.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (pre_len != 6'd0) begin
            w_state_nxt = S_PRE;
          end else if (msg_len != 6'd0) begin
            w_state_nxt = S_RD;
          end else begin
            w_state_nxt = S_FIN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRE: begin
        if (w_pre_last) begin
          if (r_msg_len != 6'd0) begin
            w_state_nxt = S_RD;
          end else begin
            w_state_nxt = S_FIN;
          end
        end else begin
          w_state_nxt = S_PRE;
        end
      end
      S_RD: begin
        w_state_nxt = S_WR;
      end
      S_WR: begin
        if (w_msg_last) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Configuration latch, byte counter, keystream and busy/done flags.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_k       <= 7'd0;
      r_lfsr    <= 6'h00;
      r_taps    <= 6'h00;
      r_pre_len <= 6'd0;
      r_msg_len <= 6'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_PRE) || (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
      if (w_start_acc) begin
        r_k       <= 7'd0;
        r_lfsr    <= (lfsr_seed == 6'h00) ? 6'h01 : lfsr_seed;
        r_taps    <= tap_lookup(tap_sel);
        r_pre_len <= pre_len;
        r_msg_len <= msg_len;
        r_done    <= 1'b0;
      end else if (w_eng_we) begin
        r_k    <= r_k + 7'd1;
        r_lfsr <= lfsr_step(r_lfsr, r_taps);
      end else if (r_state == S_FIN) begin
        r_done <= 1'b1;
      end else begin
        r_done <= r_done;
      end
    end
  end

  // Memory array: engine writes while busy, host writes only while idle.
  always_ff @(posedge clk) begin
    if (w_eng_we) begin
      r_mem[w_eng_addr] <= w_eng_wdata;
    end else if (wr_en && !r_busy) begin
      r_mem[waddr] <= data_in;
    end
    r_rd_data <= r_mem[w_src_addr];
  end

  // Host read port, one cycle latency, cleared by reset.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_data_out <= 8'h00;
    end else begin
      r_data_out <= r_mem[raddr];
    end
  end

endmodule

// File: tb/tb_lfsr_encryptor.sv
// Self-checking bench for lfsr_encryptor: a cycle-level behavioural model of
// memory, busy and done, checked every cycle, plus literal expectations.
module tb_lfsr_encryptor;

  logic       clk = 1'b0;
  logic       init;
  logic       start;
  logic       wr_en;
  logic [7:0] waddr;
  logic [7:0] data_in;
  logic [7:0] raddr;
  logic [7:0] data_out;
  logic [5:0] lfsr_seed;
  logic [2:0] tap_sel;
  logic [5:0] pre_len;
  logic [5:0] msg_len;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  lfsr_encryptor dut (
    .clk(clk), .init(init), .start(start), .wr_en(wr_en), .waddr(waddr),
    .data_in(data_in), .raddr(raddr), .data_out(data_out),
    .lfsr_seed(lfsr_seed), .tap_sel(tap_sel), .pre_len(pre_len),
    .msg_len(msg_len), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]   m_mem [0:255];
  logic [255:0] m_valid = '0;
  bit           m_run;
  int           m_e;      // clock edges since the accepted start edge
  int           m_L;      // pre_len + 2*msg_len
  int           m_pre;
  int           m_msg;
  logic [5:0]   m_seed;
  logic [5:0]   m_taps;
  logic [7:0]   m_dout;
  bit           m_dout_ok;
  bit           exp_busy;
  bit           exp_done;

  function automatic logic [5:0] tap_of(input logic [2:0] sel);
    case (sel)
      3'd1:    return 6'h2D;
      3'd2:    return 6'h30;
      3'd3:    return 6'h33;
      3'd4:    return 6'h36;
      3'd5:    return 6'h39;
      default: return 6'h21;
    endcase
  endfunction

  // Keystream state number k, obtained by stepping from the (zero-fixed) seed.
  function automatic logic [5:0] ks(input logic [5:0] seed, input logic [5:0] taps, input int k);
    logic [5:0] s;
    s = (seed == 6'h00) ? 6'h01 : seed;
    for (int i = 0; i < k; i++) begin
      s = {s[4:0], 1'($countones(s & taps) % 2)};
    end
    return s;
  endfunction

  always @(posedge clk or posedge init) begin
    if (init) begin
      m_run     <= 1'b0;
      m_e       <= 0;
      m_L       <= 0;
      m_dout    <= 8'h00;
      m_dout_ok <= 1'b1;
    end else begin
      bit         cur_busy;
      bit         idle;
      int         wedge;
      logic [7:0] src;
      cur_busy  = m_run && (m_e < m_L);
      idle      = !m_run || (m_e >= m_L + 1);
      m_dout    <= m_mem[raddr];
      m_dout_ok <= m_valid[raddr];
      if (m_run) begin
        for (int k = 0; k < m_pre + m_msg; k++) begin
          wedge = (k < m_pre) ? k + 1 : m_pre + 2 * (k - m_pre) + 2;
          if (wedge == m_e + 1) begin
            src = (k < m_pre) ? 8'h5F : m_mem[k - m_pre];
            m_mem[64 + k]   <= src ^ {2'b00, ks(m_seed, m_taps, k)};
            m_valid[64 + k] <= 1'b1;
          end
        end
      end
      if (wr_en && !cur_busy) begin
        m_mem[waddr]   <= data_in;
        m_valid[waddr] <= 1'b1;
      end
      if (start && idle) begin
        m_run  <= 1'b1;
        m_e    <= 0;
        m_pre  <= int'(pre_len);
        m_msg  <= int'(msg_len);
        m_L    <= int'(pre_len) + 2 * int'(msg_len);
        m_seed <= lfsr_seed;
        m_taps <= tap_of(tap_sel);
      end else if (m_run && (m_e < m_L + 1)) begin
        m_e <= m_e + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!init) begin
      exp_busy = m_run && (m_e < m_L);
      exp_done = m_run && (m_e >= m_L + 1);
      n_tests++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy @%0t got %b expected %b", $time, busy, exp_busy);
      end
      n_tests++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL done @%0t got %b expected %b", $time, done, exp_done);
      end
      if (m_dout_ok) begin
        n_tests++;
        if (data_out !== m_dout) begin
          n_fail++;
          $display("FAIL data_out @%0t raddr=%h got %h expected %h", $time, raddr, data_out, m_dout);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; waddr = a; data_in = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    raddr = a;
    @(negedge clk);
    check8(name, data_out, exp);
  endtask

  task automatic dump(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      raddr = 8'(a);
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(input logic [5:0] s, input logic [2:0] t, input logic [5:0] p, input logic [5:0] m);
    lfsr_seed = s; tap_sel = t; pre_len = p; msg_len = m;
  endtask

  // Pulse start, count edges until done reads 1, optionally disturb mid-run.
  task automatic run(input string name, input int exp_lat, input bit disturb);
    int lat;
    lat = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      if (disturb) begin
        case (i)
          5: begin wr_en = 1'b1; waddr = 8'd0; data_in = 8'hAA; end
          6: begin waddr = 8'd64; data_in = 8'h55; end
          7: begin wr_en = 1'b0; start = 1'b1; end
          8: start = 1'b0;
          default: ;
        endcase
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_tests++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency got %0d expected %0d", name, lat, exp_lat);
    end
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
  endtask

  // Assert init between edges and check the outputs clear without a clock.
  task automatic pulse_init_check(input string name);
    #2 init = 1'b1;
    #1;
    check8({name, "_busy"}, {7'd0, busy}, 8'h00);
    check8({name, "_done"}, {7'd0, done}, 8'h00);
    check8({name, "_dout"}, data_out, 8'h00);
    @(posedge clk); #2 init = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] exp3 [8] = '{8'h5E, 8'h5C, 8'h58, 8'h50, 8'h40, 8'h60, 8'h61, 8'h62};

  initial begin
    int p;
    int m;
    init = 1'b1; start = 1'b0; wr_en = 1'b0; waddr = 8'h00; data_in = 8'h00;
    raddr = 8'h00; set_cfg(6'h01, 3'd0, 6'd0, 6'd0);
    repeat (2) @(posedge clk);
    #2 init = 1'b0;
    @(negedge clk);

    // fill the whole memory so every read has a known expected value
    for (int a = 0; a < 256; a++) host_write(8'(a), 8'($urandom_range(0, 255)));

    // basic run
    host_write(8'h00, 8'h41);
    set_cfg(6'h01, 3'd0, 6'd2, 6'd1);
    run("basic", 5, 1'b0);
    read_chk("basic_m64", 8'd64, 8'h5E);
    read_chk("basic_m65", 8'd65, 8'h5C);
    read_chk("basic_m66", 8'd66, 8'h46);
    check8("model_pin_m66", m_mem[66], 8'h46);

    // keystream sequence
    set_cfg(6'h01, 3'd0, 6'd8, 6'd0);
    run("keystream", 9, 1'b0);
    for (int i = 0; i < 8; i++) read_chk("keystream_byte", 8'(64 + i), exp3[i]);

    // zero seed behaves as seed 1
    set_cfg(6'h00, 3'd0, 6'd2, 6'd1);
    run("seed0", 5, 1'b0);
    read_chk("seed0_m64", 8'd64, 8'h5E);
    read_chk("seed0_m66", 8'd66, 8'h46);

    // reset while done=1 and data_out nonzero
    pulse_init_check("reset_idle");

    // randomized runs over all tap selections
    for (int r = 0; r < 8; r++) begin
      p = $urandom_range(0, 20);
      m = $urandom_range(0, 20);
      for (int a = 0; a < m; a++) host_write(8'(a), 8'($urandom_range(0, 255)));
      set_cfg(6'($urandom_range(0, 63)), 3'(r), 6'(p), 6'(m));
      run("random", p + 2 * m + 1, 1'b0);
      dump(64, 64 + p + m);
    end

    // maximum run with host writes and a second start during busy
    for (int a = 0; a < 63; a++) host_write(8'(a), 8'($urandom_range(0, 255)));
    set_cfg(6'h2A, 3'd5, 6'd63, 6'd63);
    run("protect", 190, 1'b1);
    dump(0, 2);
    dump(62, 190);

    // abort during the preamble, then a full run
    set_cfg(6'h15, 3'd2, 6'd10, 6'd5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    pulse_init_check("reset_abort");
    dump(64, 80);
    run("rerun", 21, 1'b0);
    dump(64, 80);

    // empty run: no memory writes, done after one edge
    set_cfg(6'h07, 3'd1, 6'd0, 6'd0);
    run("empty", 1, 1'b0);
    dump(64, 70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
